// File: rtl/perf_counter_bank_if.sv
// Bus between the cpu-side tap logic and the performance counter bank:
// control strobes, event strobes, read port and status outputs.
interface perf_counter_bank_if #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = 6
);
  logic                  start;
  logic                  clr;
  logic [NUM_EVENTS-1:0] event_in;
  logic                  halt;
  logic                  rd_req;
  logic [SEL_W-1:0]      rd_sel;
  logic [CNT_W-1:0]      rd_data;
  logic                  rd_valid;
  logic [NUM_EVENTS:0]   ovf;
  logic [1:0]            state;
  logic                  done;
  logic                  timeout;

  modport master (
    output start, clr, event_in, halt, rd_req, rd_sel,
    input  rd_data, rd_valid, ovf, state, done, timeout
  );

  modport slave (
    input  start, clr, event_in, halt, rd_req, rd_sel,
    output rd_data, rd_valid, ovf, state, done, timeout
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Performance counter bank: NUM_EVENTS event counters plus a cycle counter,
// counting only while RUN, frozen on halt or watchdog, registered read port.

// One counter lane: increments on inc, saturates or wraps at all-ones,
// sticky overflow flag. clr wins over inc.
module perf_cnt_lane #(
  parameter int CNT_W    = 32,
  parameter bit SAT_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;

  // Next count: clear, hold, increment, or overflow handling at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = SAT_MODE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

module perf_counter_bank #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_W      = 32,
  parameter bit SAT_MODE   = 1'b1,
  parameter int WD_LIMIT   = 100000,
  parameter int SEL_W      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  perf_counter_bank_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    HALTED  = 2'b10,
    TIMEOUT = 2'b11
  } state_e;

  // Watchdog compares at 64 bits so WD_LIMIT beyond the counter range
  // simply never fires.
  localparam logic [63:0] WD_M1 = (WD_LIMIT == 0) ? 64'd0 : 64'(WD_LIMIT - 1);

  state_e state_d, state_q;
  logic   done_d, done_q;
  logic   timeout_d, timeout_q;
  logic   run, wd_hit;

  logic [NUM_EVENTS:0]            inc;
  logic [NUM_EVENTS:0]            lane_ovf;
  logic [NUM_EVENTS:0][CNT_W-1:0] cnt;

  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W-1:0] rd_data_d, rd_data_q;
  logic             rd_valid_d, rd_valid_q;

  assign run    = (state_q == RUN);
  // Top lane is the cycle counter; it advances every RUN cycle.
  assign inc    = {run, bus.event_in & {NUM_EVENTS{run}}};
  assign wd_hit = (WD_LIMIT != 0) && (64'(cnt[NUM_EVENTS]) == WD_M1);

  genvar g;
  generate
    for (g = 0; g <= NUM_EVENTS; g++) begin : g_lane
      perf_cnt_lane #(
        .CNT_W    (CNT_W),
        .SAT_MODE (SAT_MODE)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (inc[g]),
        .cnt   (cnt[g]),
        .ovf   (lane_ovf[g])
      );
    end
  endgenerate

  // FSM next state; done fires on the edge leaving RUN for a final state.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.start) state_d = RUN;
        RUN: begin
          if (bus.halt) begin
            state_d = HALTED;
            done_d  = 1'b1;
          end else if (wd_hit) begin
            state_d = TIMEOUT;
            done_d  = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
    timeout_d = (state_d == TIMEOUT);
  end

  // FSM and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Read mux over current (pre-increment, pre-clear) counter values;
  // out-of-range selects read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_EVENTS; i++) begin
      if (bus.rd_sel == SEL_W'(i)) rd_mux = cnt[i];
    end
    rd_valid_d = bus.rd_req;
    rd_data_d  = bus.rd_req ? rd_mux : rd_data_q;
  end

  // Read port registers; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ovf      = lane_ovf;
  assign bus.state    = state_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: four bank instances with different parameters share one
// stimulus stream; each check targets the instance that exercises it.
module tb_perf_counter_bank;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, clr = 1'b0, halt = 1'b0, rd_req = 1'b0;
  logic [7:0] ev = '0;
  logic [5:0] sel = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // d0: defaults; d1: 8-bit saturating; d2: 8-bit wrapping; d3: watchdog 50.
  perf_counter_bank_if #(.NUM_EVENTS(8), .CNT_W(32), .SEL_W(6)) if0 ();
  perf_counter_bank_if #(.NUM_EVENTS(8), .CNT_W(8),  .SEL_W(6)) if1 ();
  perf_counter_bank_if #(.NUM_EVENTS(8), .CNT_W(8),  .SEL_W(6)) if2 ();
  perf_counter_bank_if #(.NUM_EVENTS(8), .CNT_W(16), .SEL_W(6)) if3 ();

  assign if0.start = start; assign if0.clr = clr; assign if0.halt = halt;
  assign if0.event_in = ev; assign if0.rd_req = rd_req; assign if0.rd_sel = sel;
  assign if1.start = start; assign if1.clr = clr; assign if1.halt = halt;
  assign if1.event_in = ev; assign if1.rd_req = rd_req; assign if1.rd_sel = sel;
  assign if2.start = start; assign if2.clr = clr; assign if2.halt = halt;
  assign if2.event_in = ev; assign if2.rd_req = rd_req; assign if2.rd_sel = sel;
  assign if3.start = start; assign if3.clr = clr; assign if3.halt = halt;
  assign if3.event_in = ev; assign if3.rd_req = rd_req; assign if3.rd_sel = sel;

  perf_counter_bank #(.NUM_EVENTS(8), .CNT_W(32), .SAT_MODE(1'b1), .WD_LIMIT(100000), .SEL_W(6))
    d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  perf_counter_bank #(.NUM_EVENTS(8), .CNT_W(8), .SAT_MODE(1'b1), .WD_LIMIT(0), .SEL_W(6))
    d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  perf_counter_bank #(.NUM_EVENTS(8), .CNT_W(8), .SAT_MODE(1'b0), .WD_LIMIT(0), .SEL_W(6))
    d2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  perf_counter_bank #(.NUM_EVENTS(8), .CNT_W(16), .SAT_MODE(1'b1), .WD_LIMIT(50), .SEL_W(6))
    d3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clear everything, then start a RUN; returns just after the start edge.
  task automatic restart();
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_state", if0.state, 2'b00);
    chk("rst_valid", if0.rd_valid, 1'b0);
    chk("rst_data", if0.rd_data, 0);
    chk("rst_ovf", if0.ovf, 0);
    chk("rst_done", if0.done, 1'b0);
    chk("rst_timeout", if0.timeout, 1'b0);
    #1 rst_n = 1'b1;
    tick();

    // Basic run: ev0 for 10 cycles, then halt on the 11th RUN cycle
    start = 1'b1; tick(); start = 1'b0;
    chk("run_state", if0.state, 2'b01);
    ev[0] = 1'b1; tick(10); ev[0] = 1'b0;
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halt_state", if0.state, 2'b10);
    chk("halt_done", if0.done, 1'b1);
    chk("halt_timeout", if0.timeout, 1'b0);
    tick();
    chk("halt_done_once", if0.done, 1'b0);
    chk("halt_state_hold", if0.state, 2'b10);

    // Back-to-back reads: ev0, ev1, cycle counter, out of range
    rd_req = 1'b1; sel = 6'd0; tick();
    chk("rd0_valid", if0.rd_valid, 1'b1); chk("rd0_data", if0.rd_data, 10);
    sel = 6'd1; tick();
    chk("rd1_valid", if0.rd_valid, 1'b1); chk("rd1_data", if0.rd_data, 0);
    sel = 6'd8; tick();
    chk("rd8_valid", if0.rd_valid, 1'b1); chk("rd8_data", if0.rd_data, 11);
    sel = 6'd63; tick();
    chk("rd63_valid", if0.rd_valid, 1'b1); chk("rd63_data", if0.rd_data, 0);
    sel = 6'd8; tick(); rd_req = 1'b0; tick();
    chk("rd_idle_valid", if0.rd_valid, 1'b0);
    chk("rd_hold_data", if0.rd_data, 11);

    // start ignored while HALTED
    start = 1'b1; tick(); start = 1'b0;
    chk("halt_ignore_start", if0.state, 2'b10);

    // clr with a read of ev0 in the same cycle returns the old value
    clr = 1'b1; rd_req = 1'b1; sel = 6'd0; tick(); clr = 1'b0;
    chk("clr_rd_valid", if0.rd_valid, 1'b1);
    chk("clr_rd_old", if0.rd_data, 10);
    chk("clr_state", if0.state, 2'b00);
    chk("clr_ovf", if0.ovf, 0);
    tick();
    chk("clr_ev0_zero", if0.rd_data, 0);
    sel = 6'd8; tick(); rd_req = 1'b0;
    chk("clr_cyc_zero", if0.rd_data, 0);

    // Resume from zero: 3 event cycles + halt cycle
    start = 1'b1; tick(); start = 1'b0;
    ev[0] = 1'b1; tick(3); ev[0] = 1'b0;
    halt = 1'b1; tick(); halt = 1'b0;
    rd_req = 1'b1; sel = 6'd0; tick();
    chk("resume_ev0", if0.rd_data, 3);
    sel = 6'd8; tick(); rd_req = 1'b0;
    chk("resume_cyc", if0.rd_data, 4);

    // Overflow: ev1 for 300 cycles, then a halt cycle (301 RUN cycles)
    restart();
    ev[1] = 1'b1; tick(300); ev[1] = 1'b0;
    halt = 1'b1; tick(); halt = 1'b0;
    rd_req = 1'b1; sel = 6'd1; tick();
    chk("sat_ev1", if1.rd_data, 8'hFF);
    chk("wrap_ev1", if2.rd_data, 44);
    chk("wide_ev1", if0.rd_data, 300);
    sel = 6'd8; tick(); rd_req = 1'b0;
    chk("sat_cyc", if1.rd_data, 8'hFF);
    chk("wrap_cyc", if2.rd_data, 45);
    chk("wide_cyc", if0.rd_data, 301);
    chk("sat_ovf", if1.ovf, 9'h102);
    chk("wrap_ovf", if2.ovf, 9'h102);
    chk("wide_ovf", if0.ovf, 0);
    chk("wd_long_run_state", if3.state, 2'b11);

    // Watchdog: 49 RUN cycles stay in RUN, the 50th enters TIMEOUT
    restart();
    tick(49);
    chk("wd_pre_state", if3.state, 2'b01);
    chk("wd_pre_done", if3.done, 1'b0);
    tick();
    chk("wd_state", if3.state, 2'b11);
    chk("wd_timeout", if3.timeout, 1'b1);
    chk("wd_done", if3.done, 1'b1);
    rd_req = 1'b1; sel = 6'd8; tick(); rd_req = 1'b0;
    chk("wd_done_once", if3.done, 1'b0);
    chk("wd_cyc", if3.rd_data, 50);
    chk("wd_timeout_hold", if3.timeout, 1'b1);

    // Halt on the watchdog cycle: halt wins
    restart();
    tick(49);
    halt = 1'b1; tick(); halt = 1'b0;
    chk("wdh_state", if3.state, 2'b10);
    chk("wdh_timeout", if3.timeout, 1'b0);
    chk("wdh_done", if3.done, 1'b1);
    rd_req = 1'b1; sel = 6'd8; tick(); rd_req = 1'b0;
    chk("wdh_cyc", if3.rd_data, 50);

    // Asynchronous reset mid-RUN with a read and halt pending
    restart();
    ev[0] = 1'b1; tick(5);
    rd_req = 1'b1; sel = 6'd0; halt = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", if0.state, 2'b00);
    chk("arst_valid", if0.rd_valid, 1'b0);
    chk("arst_data", if0.rd_data, 0);
    chk("arst_done", if0.done, 1'b0);
    tick();
    ev[0] = 1'b0; rd_req = 1'b0; halt = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("arst_post_valid", if0.rd_valid, 1'b0);
    chk("arst_post_done", if0.done, 1'b0);
    chk("arst_post_state", if0.state, 2'b00);
    rd_req = 1'b1; sel = 6'd8; tick(); rd_req = 1'b0;
    chk("arst_cyc_zero", if0.rd_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
